// File: rtl/rms_calc_pkg.sv
// Shared types and width helpers for the true-RMS block.
package rms_calc_pkg;

  typedef enum logic [1:0] {
    SQ_IDLE = 2'd0,
    SQ_CALC = 2'd1,
    SQ_DONE = 2'd2
  } sqrt_state_e;

  localparam int SAMPLE_WIDTH_DEF = 16;
  localparam int WIN_LOG2_DEF     = 8;
  localparam int SQ_W             = 2 * SAMPLE_WIDTH_DEF;
  localparam int ACC_W            = SQ_W + WIN_LOG2_DEF;

  function automatic int sq_width(input int sw);
    return 2 * sw;
  endfunction

  function automatic int acc_width(input int sw, input int wl);
    return 2 * sw + wl;
  endfunction

endpackage

// File: rtl/isqrt_seq.sv
// Sequential non-restoring integer square root, one root bit per clock.
//
// state   | meaning
// SQ_IDLE | waiting for start; start is ignored in any other state
// SQ_CALC | SQRT_W iterations, one floor-root bit each
// SQ_DONE | root valid for exactly one cycle
module isqrt_seq
  import rms_calc_pkg::*;
#(
  parameter int SQRT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  abort,
  input  logic                  start,
  input  logic [2*SQRT_W-1:0]   radicand,
  output logic                  busy,
  output logic                  done,
  output logic [SQRT_W-1:0]     root
);

  localparam int RAD_W = sq_width(SQRT_W);
  localparam int REM_W = SQRT_W + 2;
  localparam int ITER_W = $clog2(SQRT_W);

  sqrt_state_e         state_q;
  logic [RAD_W-1:0]    d_q;
  logic [REM_W-1:0]    r_q;
  logic [SQRT_W-1:0]   q_q;
  logic [ITER_W-1:0]   iter_q;

  logic [REM_W-1:0]    rem_shift;
  logic [REM_W-1:0]    r_n;
  logic [SQRT_W-1:0]   q_n;

  // Remainder sign selects add or subtract; no restore step is needed for the root.
  always_comb begin
    rem_shift = {r_q[REM_W-3:0], d_q[RAD_W-1 -: 2]};
    if (r_q[REM_W-1]) begin
      r_n = rem_shift + {q_q, 2'b11};
    end else begin
      r_n = rem_shift - {q_q, 2'b01};
    end
    q_n = {q_q[SQRT_W-2:0], ~r_n[REM_W-1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SQ_IDLE;
      d_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      iter_q  <= '0;
    end else if (abort) begin
      state_q <= SQ_IDLE;
      iter_q  <= '0;
    end else begin
      case (state_q)
        SQ_IDLE: begin
          if (start) begin
            state_q <= SQ_CALC;
            d_q     <= radicand;
            r_q     <= '0;
            q_q     <= '0;
            iter_q  <= '0;
          end
        end
        SQ_CALC: begin
          d_q    <= d_q << 2;
          r_q    <= r_n;
          q_q    <= q_n;
          iter_q <= iter_q + ITER_W'(1);
          if (iter_q == ITER_W'(SQRT_W - 1)) begin
            state_q <= SQ_DONE;
          end
        end
        SQ_DONE: begin
          state_q <= SQ_IDLE;
        end
        default: begin
          state_q <= SQ_IDLE;
        end
      endcase
    end
  end

  assign busy = (state_q != SQ_IDLE);
  assign done = (state_q == SQ_DONE);
  assign root = q_q;

endmodule

// File: rtl/rms_calc.sv
// True-RMS over a 2^WIN_LOG2 sample window: square, accumulate, shift-divide,
// then a sequential square root feeding the rms/rms_ok outputs.
module rms_calc
  import rms_calc_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int WIN_LOG2     = 8,
  parameter int SQRT_W       = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic signed [SAMPLE_WIDTH-1:0] sample,
  input  logic                           sample_valid,
  output logic        [SQRT_W-1:0]       rms,
  output logic                           rms_ok,
  output logic                           rms_update,
  output logic                           overrun,
  input  logic                           overrun_clr
);

  localparam int SQ_W_L  = sq_width(SAMPLE_WIDTH);
  localparam int ACC_W_L = acc_width(SAMPLE_WIDTH, WIN_LOG2);

  logic [SQ_W_L-1:0]   sq_q,  sq_d;
  logic                sq_vld_q, sq_vld_d;
  logic                last_q, last_d;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic [ACC_W_L-1:0]  acc_q, acc_d;
  logic                overrun_q, overrun_d;
  logic [SQRT_W-1:0]   rms_q, rms_d;
  logic                rms_ok_q, rms_ok_d;
  logic                rms_update_q, rms_update_d;

  logic                       fire;
  logic signed [SQ_W_L-1:0]   sq_s;
  logic [ACC_W_L-1:0]         sum;
  logic [SQ_W_L-1:0]          mean;
  logic                       sqrt_start;
  logic                       sqrt_busy;
  logic                       sqrt_done;
  logic [SQRT_W-1:0]          sqrt_root;

  assign fire       = enable & sample_valid;
  assign sq_s       = SQ_W_L'(sample) * SQ_W_L'(sample);
  assign sum        = acc_q + ACC_W_L'(sq_q);
  assign mean       = sum[ACC_W_L-1:WIN_LOG2];
  assign sqrt_start = enable & sq_vld_q & last_q;

  always_comb begin
    sq_d         = sq_q;
    sq_vld_d     = 1'b0;
    last_d       = 1'b0;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    overrun_d    = overrun_q;
    rms_d        = rms_q;
    rms_ok_d     = rms_ok_q;
    rms_update_d = 1'b0;

    if (!enable) begin
      cnt_d    = '0;
      acc_d    = '0;
      rms_ok_d = 1'b0;
    end else begin
      if (fire) begin
        sq_d     = SQ_W_L'(sq_s);
        sq_vld_d = 1'b1;
        last_d   = (cnt_q == '1);
        cnt_d    = cnt_q + WIN_LOG2'(1);
      end
      // The closing square goes into the mean, and acc restarts empty the same cycle.
      if (sq_vld_q) begin
        acc_d = last_q ? '0 : sum;
      end
      if (sqrt_done) begin
        rms_d        = sqrt_root;
        rms_update_d = 1'b1;
        rms_ok_d     = 1'b1;
      end
    end

    if (overrun_clr) begin
      overrun_d = 1'b0;
    end
    if (sqrt_start && sqrt_busy) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq_q         <= '0;
      sq_vld_q     <= 1'b0;
      last_q       <= 1'b0;
      cnt_q        <= '0;
      acc_q        <= '0;
      overrun_q    <= 1'b0;
      rms_q        <= '0;
      rms_ok_q     <= 1'b0;
      rms_update_q <= 1'b0;
    end else begin
      sq_q         <= sq_d;
      sq_vld_q     <= sq_vld_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      overrun_q    <= overrun_d;
      rms_q        <= rms_d;
      rms_ok_q     <= rms_ok_d;
      rms_update_q <= rms_update_d;
    end
  end

  isqrt_seq #(
    .SQRT_W (SQRT_W)
  ) u_isqrt (
    .clk      (clk),
    .rst      (rst),
    .abort    (~enable),
    .start    (sqrt_start),
    .radicand (mean),
    .busy     (sqrt_busy),
    .done     (sqrt_done),
    .root     (sqrt_root)
  );

  assign rms        = rms_q;
  assign rms_ok     = rms_ok_q;
  assign rms_update = rms_update_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_rms_calc.sv
// Directed bench for rms_calc: default 256-sample instance plus a 4-sample
// window instance used to provoke overrun.
module tb_rms_calc;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic signed [15:0] sample;
  logic               sample_valid;
  logic        [15:0] rms;
  logic               rms_ok, rms_update, overrun;
  logic               overrun_clr;

  logic               enable4;
  logic signed [15:0] sample4;
  logic               sample_valid4;
  logic        [15:0] rms4;
  logic               rms_ok4, rms_update4, overrun4;
  logic               overrun_clr4;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  rms_calc #(.SAMPLE_WIDTH(16), .WIN_LOG2(8), .SQRT_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample(sample),
    .sample_valid(sample_valid), .rms(rms), .rms_ok(rms_ok),
    .rms_update(rms_update), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  rms_calc #(.SAMPLE_WIDTH(16), .WIN_LOG2(2), .SQRT_W(16)) dut4 (
    .clk(clk), .rst(rst), .enable(enable4), .sample(sample4),
    .sample_valid(sample_valid4), .rms(rms4), .rms_ok(rms_ok4),
    .rms_update(rms_update4), .overrun(overrun4), .overrun_clr(overrun_clr4)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One sample every 10 cycles; returns at the negedge right after the edge
  // that captured the last sample.
  task automatic feed(input logic signed [15:0] a, input logic signed [15:0] b,
                      input bit alt, input int split, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (alt) sample = (i % 2 == 1) ? b : a;
      else     sample = (i >= split) ? b : a;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      if (i != n - 1) repeat (8) @(negedge clk);
    end
  endtask

  // Watches 40 edges after a window end; expects one pulse 18 edges later.
  task automatic expect_result(input string name, input logic [15:0] exp_rms);
    int first = 0;
    int pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rms_update) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    total++;
    if (first !== 18) $display("FAIL %s latency: got %0d edges, want 18", name, first);
    else passed++;
    total++;
    if (pulses !== 1) $display("FAIL %s pulses: got %0d, want 1", name, pulses);
    else passed++;
    total++;
    if (rms !== exp_rms) $display("FAIL %s rms: got %0d, want %0d", name, rms, exp_rms);
    else passed++;
    total++;
    if (rms_ok !== 1'b1) $display("FAIL %s rms_ok: got %b, want 1", name, rms_ok);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b1; sample = '0; sample_valid = 1'b0; overrun_clr = 1'b0;
    enable4 = 1'b1; sample4 = '0; sample_valid4 = 1'b0; overrun_clr4 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (rms !== 16'd0) $display("FAIL reset rms: got %0d, want 0", rms); else passed++;
    total++;
    if (rms_ok !== 1'b0) $display("FAIL reset rms_ok: got %b, want 0", rms_ok); else passed++;
    total++;
    if (rms_update !== 1'b0) $display("FAIL reset rms_update: got %b, want 0", rms_update); else passed++;
    total++;
    if (overrun !== 1'b0) $display("FAIL reset overrun: got %b, want 0", overrun); else passed++;
  endtask

  task automatic test_constant();
    feed(16'sd1000, 16'sd1000, 1'b0, 256, 256);
    expect_result("const1000", 16'd1000);
  endtask

  task automatic test_alternating_then_zero();
    feed(16'sd3000, -16'sd3000, 1'b1, 0, 256);
    expect_result("alt3000", 16'd3000);
    feed(16'sd0, 16'sd0, 1'b0, 256, 256);
    expect_result("zeros", 16'd0);
  endtask

  task automatic test_full_scale();
    feed(-16'sd32768, -16'sd32768, 1'b0, 256, 256);
    expect_result("fullscale", 16'h8000);
  endtask

  task automatic test_floor();
    feed(16'sd4, 16'sd0, 1'b0, 128, 256);
    expect_result("floor_mean8", 16'd2);
  endtask

  task automatic test_back_to_back_overrun();
    int pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sample4 = 16'sd10;
      sample_valid4 = 1'b1;
    end
    @(negedge clk);
    sample_valid4 = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (rms_update4) pulses++;
    end
    total++;
    if (overrun4 !== 1'b1) $display("FAIL overrun set: got %b, want 1", overrun4); else passed++;
    total++;
    if (pulses !== 1) $display("FAIL overrun pulses: got %0d, want 1", pulses); else passed++;
    total++;
    if (rms4 !== 16'd10) $display("FAIL overrun rms: got %0d, want 10", rms4); else passed++;

    @(negedge clk); overrun_clr4 = 1'b1;
    @(negedge clk); overrun_clr4 = 1'b0;
    total++;
    if (overrun4 !== 1'b0) $display("FAIL overrun clear: got %b, want 0", overrun4); else passed++;

    // Clear held high through the edge where the second window end sets overrun.
    overrun_clr4 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sample4 = 16'sd7;
      sample_valid4 = 1'b1;
    end
    @(negedge clk);
    sample_valid4 = 1'b0;
    total++;
    if (overrun4 !== 1'b0) $display("FAIL overrun early: got %b, want 0", overrun4); else passed++;
    @(negedge clk);
    overrun_clr4 = 1'b0;
    total++;
    if (overrun4 !== 1'b1) $display("FAIL overrun set_over_clear: got %b, want 1", overrun4); else passed++;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_enable_drop();
    int pulses = 0;
    feed(16'sd700, 16'sd700, 1'b0, 256, 256);
    expect_result("pre_disable", 16'd700);
    feed(16'sd2000, 16'sd2000, 1'b0, 256, 100);
    @(negedge clk);
    enable = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (rms_update) pulses++;
    end
    total++;
    if (rms_ok !== 1'b0) $display("FAIL disable rms_ok: got %b, want 0", rms_ok); else passed++;
    total++;
    if (rms !== 16'd700) $display("FAIL disable rms hold: got %0d, want 700", rms); else passed++;
    total++;
    if (pulses !== 0) $display("FAIL disable pulses: got %0d, want 0", pulses); else passed++;
    enable = 1'b1;
    feed(16'sd500, 16'sd500, 1'b0, 256, 256);
    expect_result("reenable500", 16'd500);
  endtask

  task automatic test_async_reset();
    int pulses = 0;
    feed(16'sd1000, 16'sd1000, 1'b0, 256, 256);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (rms !== 16'd0) $display("FAIL async rst rms: got %0d, want 0", rms); else passed++;
    total++;
    if (rms_ok !== 1'b0) $display("FAIL async rst rms_ok: got %b, want 0", rms_ok); else passed++;
    total++;
    if (overrun4 !== 1'b0) $display("FAIL async rst overrun: got %b, want 0", overrun4); else passed++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rms_update) pulses++;
    end
    total++;
    if (pulses !== 0) $display("FAIL async rst pulses: got %0d, want 0", pulses); else passed++;
    total++;
    if (rms !== 16'd0) $display("FAIL async rst rms after: got %0d, want 0", rms); else passed++;
    feed(16'sd1200, 16'sd1200, 1'b0, 256, 256);
    expect_result("post_reset1200", 16'd1200);
  endtask

  initial begin
    test_reset();
    test_constant();
    test_alternating_then_zero();
    test_full_scale();
    test_floor();
    test_back_to_back_overrun();
    test_enable_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
